dsdmnist_postseq: RTL and testbench
===================================

DSDMNIST_POSTSEQ -- requirements
Module: dsdmnist_postseq

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, meaning the output-buffer address width (max 127 neurons per layer).
REQ-002 SHALL have ports:
  i_CLK  in  1  sole clock, rising edge
  i_RSTn  in  1  synchronous active-low reset
  i_START  in  1  one-cycle pulse that begins a layer pass
  i_LAYER  in  1  0 = layer 1 (k1), 1 = layer 2 (k2); sampled with i_START
  i_NUM_OUT  in  ADDR_W  neuron count for the pass; sampled with i_START
  i_ACC_VALID  in  1  accumulator result available
  i_ACC_DATA  in  25 signed  accumulator sum
  o_ACC_READY  out  1  sequencer accepts i_ACC_DATA this cycle
  o_ACCVAL_LD  out  1  load strobe to the post-calc datapath
  o_ACCVAL  out  25 signed  accumulator value to the datapath
  o_CONST  out  33 signed  Q1.32 requant constant to the datapath
  i_RESULT  in  8  unsigned int8 result from the datapath
  o_WR_EN  out  1  output-buffer write strobe
  o_WR_ADDR  out  ADDR_W  write address (neuron index)
  o_WR_DATA  out  8  write data
  o_BUSY  out  1  pass in progress
  o_DONE  out  1  one-cycle pulse, pass complete
  o_CLASS  out  4  argmax index of the last layer-2 pass
  o_CLASS_VLD  out  1  o_CLASS is valid

Function
REQ-003 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-004 IDLE: on i_START with i_NUM_OUT != 0, latch the layer and count, select o_CONST (K1 = 10740662 for layer 0, K2 = 36764431 for layer 1), and go to RUN.
REQ-005 IDLE: on i_START with i_NUM_OUT == 0, go to DONE with no writes.
REQ-006 i_START outside IDLE SHALL be ignored.
REQ-007 o_ACC_READY SHALL be 1 only in RUN; an accept is i_ACC_VALID & o_ACC_READY.
REQ-008 On an accept, o_ACCVAL_LD SHALL be 1 and o_ACCVAL SHALL equal i_ACC_DATA in the same cycle (combinational pass-through); the issue counter SHALL then increment.
REQ-009 RUN -> DRAIN SHALL occur on the accept that issues the i_NUM_OUT-th value.
REQ-010 o_CONST SHALL remain constant from leaving IDLE until after DONE, so it is stable for the datapath's two post-load stages.
REQ-011 Datapath latency is fixed: i_RESULT for a load at edge t is valid in the cycle after edge t+2. A 3-stage valid shift register SHALL track this latency.
REQ-012 At stage 3: o_WR_EN = 1, o_WR_DATA = i_RESULT, o_WR_ADDR = write counter (starting at 0, incrementing per write).
REQ-013 DRAIN -> DONE SHALL occur when the i_NUM_OUT-th write is issued; DONE lasts one cycle (o_DONE = 1), then returns to IDLE.
REQ-014 o_BUSY SHALL be 1 in RUN, DRAIN and DONE.
REQ-015 Layer-2 passes SHALL track a running maximum of o_WR_DATA (unsigned) and its address. Update only on strictly greater, so ties keep the lowest index; the first write always loads.
REQ-016 o_CLASS / o_CLASS_VLD SHALL update in the DONE cycle of a layer-2 pass. o_CLASS_VLD SHALL clear on the next accepted i_START.
REQ-017 Back-to-back accepts (one per cycle) SHALL be supported without stall; gaps in i_ACC_VALID SHALL be tolerated.

Reset
REQ-018 With i_RSTn = 0 at a clock edge: state = IDLE; all counters, valid pipe and argmax registers cleared; outputs o_ACC_READY, o_ACCVAL_LD, o_WR_EN, o_BUSY, o_DONE, o_CLASS_VLD = 0; o_CLASS = 0; o_CONST = K1.
REQ-019 Reset mid-pass SHALL drop in-flight results: no o_WR_EN after the reset edge.

Structure
REQ-020 K1, K2, the state enum and the datapath latency (3) SHALL live in package dsdmnist_pkg.
REQ-021 The sequencer SHALL instantiate no sub-modules. The dsdmnist_postcalc datapath is instantiated by the parent and sits between o_ACCVAL/o_CONST and i_RESULT.

Verification
REQ-022 Layer 0, NUM_OUT = 4, values {100, -5, 0, 400000} back-to-back -> writes at addr 0..3 with data {0, 0, 0, 127}; exactly 3 cycles from each LD to its write; o_DONE one cycle after the last write.
REQ-023 Layer 1, NUM_OUT = 10, gapped valid, results with the maximum 90 at indices 3 and 7 -> o_CLASS = 3, o_CLASS_VLD = 1 in the DONE cycle.
REQ-024 NUM_OUT = 0 -> o_DONE one cycle after i_START; no o_ACCVAL_LD, no o_WR_EN.
REQ-025 i_START pulsed during RUN -> ignored; the count and o_CONST are unchanged.
REQ-026 i_RSTn low two cycles after the final accept -> no writes follow; state IDLE; o_BUSY = 0.
REQ-027 Layer 0 then layer 1 back-to-back -> o_CONST = 10740662 in the first pass, 36764431 in the second, stable throughout each pass.

Source files
------------

// File: rtl/dsdmnist_pkg.sv
// Shared constants and state encoding for the post-accumulation sequencer.
package dsdmnist_pkg;

    // Q1.32 requant multipliers for the two layers
    localparam logic signed [32:0] K1 = 33'sd10740662;
    localparam logic signed [32:0] K2 = 33'sd36764431;

    // Load-to-result latency of the postcalc datapath
    localparam int PIPE_LAT = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/dsdmnist_postseq.sv
// Feeds accumulator sums into the fixed-latency requant datapath, writes the
// int8 results to the output buffer and tracks the layer-2 argmax.
module dsdmnist_postseq
    import dsdmnist_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic                     i_CLK,
    input  logic                     i_RSTn,
    input  logic                     i_START,
    input  logic                     i_LAYER,
    input  logic [ADDR_W-1:0]        i_NUM_OUT,
    input  logic                     i_ACC_VALID,
    input  logic signed [24:0]       i_ACC_DATA,
    output logic                     o_ACC_READY,
    output logic                     o_ACCVAL_LD,
    output logic signed [24:0]       o_ACCVAL,
    output logic signed [32:0]       o_CONST,
    input  logic [7:0]               i_RESULT,
    output logic                     o_WR_EN,
    output logic [ADDR_W-1:0]        o_WR_ADDR,
    output logic [7:0]               o_WR_DATA,
    output logic                     o_BUSY,
    output logic                     o_DONE,
    output logic [3:0]               o_CLASS,
    output logic                     o_CLASS_VLD
);

    state_t              state;
    logic                layer;
    logic [ADDR_W-1:0]   num_out;
    logic [ADDR_W-1:0]   iss_cnt;
    logic [ADDR_W-1:0]   wr_cnt;
    logic [PIPE_LAT:1]   vld_pipe;
    logic [7:0]          max_val;
    logic [3:0]          max_idx;

    logic                accept;
    logic                last_iss;
    logic                last_wr;
    logic                am_upd;
    logic [3:0]          am_idx;

    always_comb begin
        o_ACC_READY = (state == RUN);
        o_BUSY      = (state != IDLE);
        o_DONE      = (state == DONE);
        accept      = i_ACC_VALID & o_ACC_READY;
        o_ACCVAL_LD = accept;
        o_ACCVAL    = i_ACC_DATA;
        o_WR_EN     = vld_pipe[PIPE_LAT];
        o_WR_ADDR   = wr_cnt;
        o_WR_DATA   = i_RESULT;
        last_iss    = (iss_cnt == num_out - ADDR_W'(1));
        last_wr     = o_WR_EN && (wr_cnt == num_out - ADDR_W'(1));
        // strict compare keeps the lowest index on ties; first write always loads
        am_upd      = o_WR_EN && layer && ((wr_cnt == '0) || (i_RESULT > max_val));
        am_idx      = am_upd ? wr_cnt[3:0] : max_idx;
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            state       <= IDLE;
            layer       <= 1'b0;
            num_out     <= '0;
            iss_cnt     <= '0;
            wr_cnt      <= '0;
            vld_pipe    <= '0;
            max_val     <= '0;
            max_idx     <= '0;
            o_CONST     <= K1;
            o_CLASS     <= '0;
            o_CLASS_VLD <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[PIPE_LAT-1:1], accept};
            if (o_WR_EN)
                wr_cnt <= wr_cnt + ADDR_W'(1);
            if (am_upd) begin
                max_val <= i_RESULT;
                max_idx <= wr_cnt[3:0];
            end

            unique case (state)
                IDLE: begin
                    if (i_START) begin
                        o_CLASS_VLD <= 1'b0;
                        layer       <= i_LAYER;
                        num_out     <= i_NUM_OUT;
                        iss_cnt     <= '0;
                        wr_cnt      <= '0;
                        if (i_NUM_OUT != '0) begin
                            o_CONST <= i_LAYER ? K2 : K1;
                            state   <= RUN;
                        end else begin
                            state   <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        iss_cnt <= iss_cnt + ADDR_W'(1);
                        if (last_iss)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_wr) begin
                        state <= DONE;
                        if (layer) begin
                            o_CLASS     <= am_idx;
                            o_CLASS_VLD <= 1'b1;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsdmnist_postseq.sv
// Scoreboard bench for dsdmnist_postseq with a behavioural 3-cycle datapath.
module tb_dsdmnist_postseq;

    localparam int AW = 7;
    localparam logic signed [32:0] TK1 = 33'sd10740662;
    localparam logic signed [32:0] TK2 = 33'sd36764431;

    logic                 i_CLK = 1'b0;
    logic                 i_RSTn;
    logic                 i_START;
    logic                 i_LAYER;
    logic [AW-1:0]        i_NUM_OUT;
    logic                 i_ACC_VALID;
    logic signed [24:0]   i_ACC_DATA;
    logic                 o_ACC_READY;
    logic                 o_ACCVAL_LD;
    logic signed [24:0]   o_ACCVAL;
    logic signed [32:0]   o_CONST;
    logic [7:0]           i_RESULT = 8'd0;
    logic                 o_WR_EN;
    logic [AW-1:0]        o_WR_ADDR;
    logic [7:0]           o_WR_DATA;
    logic                 o_BUSY;
    logic                 o_DONE;
    logic [3:0]           o_CLASS;
    logic                 o_CLASS_VLD;

    dsdmnist_postseq #(.ADDR_W(AW)) dut (
        .i_CLK(i_CLK), .i_RSTn(i_RSTn), .i_START(i_START), .i_LAYER(i_LAYER),
        .i_NUM_OUT(i_NUM_OUT), .i_ACC_VALID(i_ACC_VALID), .i_ACC_DATA(i_ACC_DATA),
        .o_ACC_READY(o_ACC_READY), .o_ACCVAL_LD(o_ACCVAL_LD), .o_ACCVAL(o_ACCVAL),
        .o_CONST(o_CONST), .i_RESULT(i_RESULT), .o_WR_EN(o_WR_EN),
        .o_WR_ADDR(o_WR_ADDR), .o_WR_DATA(o_WR_DATA), .o_BUSY(o_BUSY),
        .o_DONE(o_DONE), .o_CLASS(o_CLASS), .o_CLASS_VLD(o_CLASS_VLD)
    );

    always #5 i_CLK = ~i_CLK;

    int cyc = 0;
    always @(posedge i_CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Requant reference: round(acc * K / 2^32), clamped to 0..127
    function automatic logic [7:0] model(input logic signed [24:0] a, input logic signed [32:0] k);
        longint p;
        p = longint'(a) * longint'(k);
        p = (p + 64'sd2147483648) >>> 32;
        if (p < 0) return 8'd0;
        if (p > 127) return 8'd127;
        return 8'(p);
    endfunction

    // Stand-in datapath: raw_mode passes the low byte through for argmax tests
    bit raw_mode = 1'b0;
    logic [7:0] dp1 = 8'd0, dp2 = 8'd0;
    always @(posedge i_CLK) begin
        dp1      <= o_ACCVAL_LD ? (raw_mode ? o_ACCVAL[7:0] : model(o_ACCVAL, o_CONST)) : 8'd0;
        dp2      <= dp1;
        i_RESULT <= dp2;
    end

    typedef struct {
        int         addr;
        logic [7:0] data;
        int         wcyc;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;
    int   wr_count = 0;
    int   last_wr_cyc = 0;

    always @(negedge i_CLK) begin
        if (o_WR_EN === 1'b1) begin
            wr_count++;
            last_wr_cyc = cyc;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%0d cyc=%0d", o_WR_ADDR, o_WR_DATA, cyc);
            end else begin
                mon_e = sbq.pop_front();
                if (o_WR_ADDR !== AW'(mon_e.addr) || o_WR_DATA !== mon_e.data || cyc != mon_e.wcyc) begin
                    errors++;
                    $display("FAIL write got addr=%0d data=%0d cyc=%0d want addr=%0d data=%0d cyc=%0d",
                             o_WR_ADDR, o_WR_DATA, cyc, mon_e.addr, mon_e.data, mon_e.wcyc);
                end
            end
        end
    end

    task automatic start(input logic l, input int n);
        i_START = 1'b1; i_LAYER = l; i_NUM_OUT = AW'(n);
        @(negedge i_CLK);
        i_START = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_CLK);
            if (o_DONE === 1'b1) begin seen = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        i_RSTn = 1'b0; i_START = 1'b0; i_LAYER = 1'b0; i_NUM_OUT = '0;
        i_ACC_VALID = 1'b0; i_ACC_DATA = '0;
        repeat (2) @(negedge i_CLK);
        checks++;
        if ({o_ACC_READY, o_ACCVAL_LD, o_WR_EN, o_BUSY, o_DONE, o_CLASS_VLD, o_CLASS} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0", {o_ACC_READY, o_ACCVAL_LD, o_WR_EN, o_BUSY, o_DONE, o_CLASS_VLD, o_CLASS});
        end
        checks++;
        if (o_CONST !== TK1) begin errors++; $display("FAIL reset_const got %0d want %0d", o_CONST, TK1); end
        i_RSTn = 1'b1;
        @(negedge i_CLK);
    endtask

    task automatic test_layer0();
        logic signed [24:0] v[4] = '{25'sd100, -25'sd5, 25'sd0, 25'sd400000};
        logic [7:0]         d[4] = '{8'd0, 8'd0, 8'd0, 8'd127};
        bit seen;
        start(1'b0, 4);
        checks++;
        if (o_BUSY !== 1'b1 || o_ACC_READY !== 1'b1 || o_CONST !== TK1) begin
            errors++;
            $display("FAIL l0_run busy=%b ready=%b const=%0d want 1 1 %0d", o_BUSY, o_ACC_READY, o_CONST, TK1);
        end
        for (int i = 0; i < 4; i++) begin
            i_ACC_VALID = 1'b1; i_ACC_DATA = v[i];
            #1;
            checks++;
            if (o_ACCVAL_LD !== 1'b1 || o_ACCVAL !== v[i]) begin
                errors++;
                $display("FAIL l0_load%0d ld=%b val=%0d want 1 %0d", i, o_ACCVAL_LD, o_ACCVAL, v[i]);
            end
            sbq.push_back('{addr: i, data: d[i], wcyc: cyc + 3});
            @(negedge i_CLK);
        end
        i_ACC_VALID = 1'b0;
        checks++;
        if (o_ACC_READY !== 1'b0 || o_BUSY !== 1'b1) begin
            errors++;
            $display("FAIL l0_drain ready=%b busy=%b want 0 1", o_ACC_READY, o_BUSY);
        end
        wait_done(seen);
        checks++;
        if (!seen || cyc != last_wr_cyc + 1 || sbq.size() != 0) begin
            errors++;
            $display("FAIL l0_done seen=%0d cyc=%0d want %0d pending=%0d want 0", seen, cyc, last_wr_cyc + 1, sbq.size());
        end
        @(negedge i_CLK);
        checks++;
        if (o_BUSY !== 1'b0 || o_DONE !== 1'b0) begin
            errors++;
            $display("FAIL l0_idle busy=%b done=%b want 0 0", o_BUSY, o_DONE);
        end
    endtask

    task automatic test_argmax();
        logic signed [24:0] v[10] = '{25'sd10, 25'sd20, 25'sd5, 25'sd90, 25'sd3,
                                      25'sd40, 25'sd60, 25'sd90, 25'sd1, 25'sd2};
        bit seen;
        raw_mode = 1'b1;
        start(1'b1, 10);
        checks++;
        if (o_CONST !== TK2) begin errors++; $display("FAIL am_const got %0d want %0d", o_CONST, TK2); end
        for (int i = 0; i < 10; i++) begin
            i_ACC_VALID = 1'b1; i_ACC_DATA = v[i];
            #1;
            checks++;
            if (o_ACCVAL_LD !== 1'b1) begin errors++; $display("FAIL am_load%0d ld=%b want 1", i, o_ACCVAL_LD); end
            sbq.push_back('{addr: i, data: v[i][7:0], wcyc: cyc + 3});
            @(negedge i_CLK);
            if (i % 2 == 1) begin
                i_ACC_VALID = 1'b0;
                @(negedge i_CLK);
            end
        end
        i_ACC_VALID = 1'b0;
        wait_done(seen);
        checks++;
        if (!seen || o_CLASS !== 4'd3 || o_CLASS_VLD !== 1'b1) begin
            errors++;
            $display("FAIL am_class seen=%0d class=%0d vld=%b want 1 3 1", seen, o_CLASS, o_CLASS_VLD);
        end
        @(negedge i_CLK);
        raw_mode = 1'b0;
        checks++;
        if (o_CLASS !== 4'd3 || o_CLASS_VLD !== 1'b1) begin
            errors++;
            $display("FAIL am_hold class=%0d vld=%b want 3 1", o_CLASS, o_CLASS_VLD);
        end
    endtask

    task automatic test_zero();
        int wc;
        wc = wr_count;
        i_ACC_VALID = 1'b1; i_ACC_DATA = 25'sd1234;
        start(1'b0, 0);
        checks++;
        if (o_DONE !== 1'b1 || o_ACCVAL_LD !== 1'b0 || o_CLASS_VLD !== 1'b0) begin
            errors++;
            $display("FAIL zero_done done=%b ld=%b cvld=%b want 1 0 0", o_DONE, o_ACCVAL_LD, o_CLASS_VLD);
        end
        @(negedge i_CLK);
        checks++;
        if (o_DONE !== 1'b0 || o_BUSY !== 1'b0 || o_ACCVAL_LD !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle done=%b busy=%b ld=%b want 0 0 0", o_DONE, o_BUSY, o_ACCVAL_LD);
        end
        i_ACC_VALID = 1'b0;
        repeat (4) @(negedge i_CLK);
        checks++;
        if (wr_count != wc) begin errors++; $display("FAIL zero_writes got %0d want %0d", wr_count - wc, 0); end
    endtask

    task automatic test_start_ignored();
        logic signed [24:0] v[3] = '{25'sd30000, 25'sd120000, 25'sd7};
        bit seen;
        start(1'b0, 3);
        for (int i = 0; i < 3; i++) begin
            i_ACC_VALID = 1'b1; i_ACC_DATA = v[i];
            if (i == 1) begin i_START = 1'b1; i_LAYER = 1'b1; i_NUM_OUT = AW'(5); end
            sbq.push_back('{addr: i, data: model(v[i], TK1), wcyc: cyc + 3});
            @(negedge i_CLK);
            i_START = 1'b0;
            checks++;
            if (o_CONST !== TK1) begin errors++; $display("FAIL ign_const%0d got %0d want %0d", i, o_CONST, TK1); end
        end
        i_ACC_VALID = 1'b0;
        wait_done(seen);
        checks++;
        if (!seen || sbq.size() != 0 || o_CONST !== TK1) begin
            errors++;
            $display("FAIL ign_done seen=%0d pending=%0d const=%0d want 1 0 %0d", seen, sbq.size(), o_CONST, TK1);
        end
        repeat (4) @(negedge i_CLK);
        checks++;
        if (o_BUSY !== 1'b0) begin errors++; $display("FAIL ign_idle busy=%b want 0", o_BUSY); end
    endtask

    task automatic test_back_to_back();
        logic signed [24:0] va[3] = '{25'sd50000, 25'sd200000, -25'sd7};
        logic [7:0]         da[3] = '{8'd125, 8'd127, 8'd0};
        logic signed [24:0] vb[3] = '{25'sd5000, 25'sd1000, 25'sd70000};
        logic [7:0]         db[3] = '{8'd43, 8'd9, 8'd127};
        int bad;
        bit seen;
        for (int p = 0; p < 2; p++) begin
            logic signed [32:0] k;
            k = (p == 0) ? TK1 : TK2;
            bad = 0;
            start(p[0], 3);
            for (int i = 0; i < 3; i++) begin
                i_ACC_VALID = 1'b1; i_ACC_DATA = (p == 0) ? va[i] : vb[i];
                sbq.push_back('{addr: i, data: (p == 0) ? da[i] : db[i], wcyc: cyc + 3});
                if (o_CONST !== k) bad++;
                @(negedge i_CLK);
            end
            i_ACC_VALID = 1'b0;
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                if (o_CONST !== k) bad++;
                if (o_DONE === 1'b1) seen = 1'b1;
                else @(negedge i_CLK);
            end
            checks++;
            if (!seen || bad != 0 || sbq.size() != 0) begin
                errors++;
                $display("FAIL b2b_pass%0d seen=%0d const_bad=%0d const=%0d want %0d pending=%0d",
                         p, seen, bad, o_CONST, k, sbq.size());
            end
            @(negedge i_CLK);
        end
    endtask

    task automatic test_reset_mid();
        int wc;
        start(1'b0, 3);
        for (int i = 0; i < 3; i++) begin
            i_ACC_VALID = 1'b1; i_ACC_DATA = 25'sd100000 * (i + 1);
            sbq.push_back('{addr: i, data: model(25'sd100000 * (i + 1), TK1), wcyc: cyc + 3});
            @(negedge i_CLK);
        end
        i_ACC_VALID = 1'b0;
        @(negedge i_CLK);
        i_RSTn = 1'b0;
        @(negedge i_CLK);
        checks++;
        if (sbq.size() != 1 || o_BUSY !== 1'b0 || o_ACC_READY !== 1'b0 || o_WR_EN !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid pending=%0d busy=%b ready=%b wr=%b want 1 0 0 0",
                     sbq.size(), o_BUSY, o_ACC_READY, o_WR_EN);
        end
        sbq.delete();
        wc = wr_count;
        @(negedge i_CLK);
        i_RSTn = 1'b1;
        repeat (5) @(negedge i_CLK);
        checks++;
        if (wr_count != wc || o_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL rst_after writes=%0d busy=%b want 0 0", wr_count - wc, o_BUSY);
        end
    endtask

    initial begin
        test_reset();
        test_layer0();
        test_argmax();
        test_zero();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
